booth_pp_accumulator: RTL and testbench

- Receiving end of the radix-4 Booth partial-product interface. Accepts one Booth partial product per beat (PP word plus SIGN bit) in digit order, least-significant digit first.
- Weights each partial product by 4^i, accumulates them, and returns the unsigned 2N-bit product to the Barrett datapath through a valid/ready handshake.
- Sits directly downstream of the Booth encoder row, replacing a combinational adder tree with a sequential one.

---
 rtl/booth_pp_accumulator_pkg.sv | 26 ++
 rtl/booth_pp_accumulator_if.sv | 24 ++
 rtl/booth_pp_align.sv | 21 ++
 rtl/booth_pp_accumulator.sv | 89 ++++++++
 tb/tb_booth_pp_accumulator.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/booth_pp_accumulator_pkg.sv
// Shared types and width helpers for the sequential radix-4 Booth partial-product accumulator.
package booth_pp_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEF_N = 1024;

  // Radix-4 digits needed to cover an unsigned N-bit multiplier (N must be even).
  function automatic int booth_k(input int n);
    return n / 2 + 1;
  endfunction

  // 2N product bits plus headroom for negative intermediate sums.
  function automatic int acc_width(input int n);
    return 2 * n + 3;
  endfunction

  function automatic int cnt_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/booth_pp_accumulator_if.sv
// Partial-product input beat, product output handshake and control for the accumulator.
interface booth_pp_accumulator_if #(
  parameter int N = booth_pp_accumulator_pkg::DEF_N
);
  logic           clr;
  logic           in_valid;
  logic           in_ready;
  logic [N:0]     in_pp;
  logic           in_sign;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_product;
  logic           busy;

  modport master (
    output clr, in_valid, in_pp, in_sign, out_ready,
    input  in_ready, out_valid, out_product, busy
  );

  modport slave (
    input  clr, in_valid, in_pp, in_sign, out_ready,
    output in_ready, out_valid, out_product, busy
  );
endinterface

// File: rtl/booth_pp_align.sv
// Turns one Booth beat into its signed, 4^digit-weighted term at accumulator width.
module booth_pp_align #(
  parameter int N     = 8,
  parameter int ACC_W = 2 * N + 3,
  parameter int CW    = 3
) (
  input  logic [N:0]       pp_i,
  input  logic             sign_i,
  input  logic [CW-1:0]    digit_i,
  output logic [ACC_W-1:0] term_o
);
  logic [ACC_W-1:0] val;
  logic [CW:0]      shamt;

  // {sign,pp} is an (N+2)-bit two's-complement word; adding sign completes the negation.
  always_comb begin
    val    = {{(ACC_W-N-2){sign_i}}, sign_i, pp_i} + {{(ACC_W-1){1'b0}}, sign_i};
    shamt  = {digit_i, 1'b0};
    term_o = val << shamt;
  end
endmodule

// File: rtl/booth_pp_accumulator.sv
// Sequential accumulator for radix-4 Booth partial products; returns the unsigned 2N-bit product.
module booth_pp_accumulator
  import booth_pp_accumulator_pkg::*;
#(
  parameter int N = DEF_N
) (
  input logic                   clk,
  input logic                   rst,
  booth_pp_accumulator_if.slave bus
);
  localparam int K     = booth_k(N);
  localparam int ACC_W = acc_width(N);
  localparam int CW    = cnt_width(K);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [2*N-1:0]   prod_q, prod_d;
  logic [ACC_W-1:0] term;
  logic             beat;

  booth_pp_align #(.N(N), .ACC_W(ACC_W), .CW(CW)) u_align (
    .pp_i    (bus.in_pp),
    .sign_i  (bus.in_sign),
    .digit_i (cnt_q),
    .term_o  (term)
  );

  assign bus.in_ready    = (state_q != DONE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.out_product = prod_q;
  assign beat            = bus.in_valid & bus.in_ready;

  // cnt_q is 0 in IDLE, so IDLE and ACCUM share the beat path; the last digit closes the job.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    if (bus.clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, ACCUM: begin
          if (beat) begin
            acc_d = acc_q + term;
            if (cnt_q == LAST) begin
              prod_d  = acc_d[2*N-1:0];
              state_d = DONE;
            end else begin
              cnt_d   = cnt_q + 1'b1;
              state_d = ACCUM;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          acc_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end
endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Randomized and directed bench: Booth digits are derived from the multiplier, products from plain X*Y.
module tb_booth_pp_accumulator;
  localparam int N = 8;
  localparam int K = N / 2 + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  booth_pp_accumulator_if #(.N(N)) bus ();
  booth_pp_accumulator #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [N:0] pp_q[$];
  logic       sign_q[$];
  logic [2*N-1:0] last_prod = '0;

  always @(negedge clk) cyc++;

  // Radix-4 digit i of unsigned x: x[2i] + x[2i-1] - 2*x[2i+1], with x[-1]=0 and zero beyond N.
  function automatic int digit(input logic [N-1:0] x, input int i);
    logic [N+1:0] xe;
    int b0, b1, b2;
    xe = {2'b00, x};
    b0 = (i > 0) ? int'(xe[2*i-1]) : 0;
    b1 = int'(xe[2*i]);
    b2 = int'(xe[2*i+1]);
    return b1 + b0 - 2 * b2;
  endfunction

  // zneg: 0 zeros as (0,0), 1 zeros as (all-ones,1), 2 random choice.
  task automatic build(input logic [N-1:0] x, input logic [N-1:0] y, input int zneg);
    int d;
    logic [N:0] m;
    bit zn;
    pp_q.delete();
    sign_q.delete();
    for (int i = 0; i < K; i++) begin
      d = digit(x, i);
      m = (d == 2 || d == -2) ? {y, 1'b0} : (d == 1 || d == -1) ? {1'b0, y} : '0;
      zn = (zneg == 1) || (zneg == 2 && $urandom_range(1) == 1);
      if (d < 0) begin
        pp_q.push_back(~m); sign_q.push_back(1'b1);
      end else if (d == 0 && zn) begin
        pp_q.push_back('1); sign_q.push_back(1'b1);
      end else begin
        pp_q.push_back(m); sign_q.push_back(1'b0);
      end
    end
  endtask

  // Present the first n queued beats back to back; returns at the negedge after the last accept.
  task automatic send_beats(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_pp = pp_q[i]; bus.in_sign = sign_q[i]; bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_job(input string nm, input logic [N-1:0] x, input logic [N-1:0] y,
                         input int zneg, input int gap, input int hold, input logic [2*N-1:0] exp);
    int g;
    build(x, y, zneg);
    for (int i = 0; i < K; i++) begin
      repeat (gap) @(negedge clk);
      bus.in_pp = pp_q[i]; bus.in_sign = sign_q[i]; bus.in_valid = 1'b1;
      g = 0;
      while (bus.in_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
      checks++;
      if (g >= 50) begin errors++; $display("FAIL %s beat%0d_timeout in_ready=%b required=1", nm, i, bus.in_ready); end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_pp = N'($urandom);
      if (i < K - 1) begin
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL %s mid_job beat%0d out_valid=%b busy=%b required out_valid=0 busy=1", nm, i, bus.out_valid, bus.busy);
        end
      end
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL %s latency out_valid=%b in_ready=%b required 1/0", nm, bus.out_valid, bus.in_ready);
    end
    checks++;
    if (bus.out_product !== exp) begin
      errors++; $display("FAIL %s product got=%h required=%h (x=%0d y=%0d)", nm, bus.out_product, exp, x, y);
    end
    // Stall the output while the upstream offers a beat that must not be taken.
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1; bus.in_pp = N'($urandom); bus.in_sign = 1'($urandom);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_product !== exp) begin
        errors++;
        $display("FAIL %s hold%0d out_valid=%b in_ready=%b product=%h required 1/0/%h", nm, h, bus.out_valid, bus.in_ready, bus.out_product, exp);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s release out_valid=%b in_ready=%b busy=%b required 0/1/0", nm, bus.out_valid, bus.in_ready, bus.busy);
    end
    last_prod = exp;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_product !== '0) begin
      errors++;
      $display("FAIL reset out_valid=%b in_ready=%b busy=%b product=%h required 0/1/0/0", bus.out_valid, bus.in_ready, bus.busy, bus.out_product);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_job("s1_3x5", 8'd3, 8'd5, 0, 0, 0, 16'h000F);
    run_job("s2_255x255", 8'd255, 8'd255, 1, 0, 0, 16'hFE01);
    run_job("s3_2x7", 8'd2, 8'd7, 0, 0, 0, 16'h000E);
  endtask

  task automatic test_backpressure();
    run_job("s4_hold", 8'd3, 8'd5, 0, 0, 10, 16'h000F);
    run_job("s4_next", 8'd200, 8'd123, 2, 0, 0, 16'd24600);
  endtask

  task automatic test_gaps();
    run_job("s5_gaps", 8'd255, 8'd255, 1, 3, 0, 16'hFE01);
  endtask

  task automatic test_abort();
    logic [2*N-1:0] held;
    held = last_prod;
    build(8'd3, 8'd5, 0);
    send_beats(2);
    // clr beats a beat offered in the same cycle.
    bus.in_pp = pp_q[2]; bus.in_sign = sign_q[2]; bus.in_valid = 1'b1; bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0; bus.in_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_product !== held) begin
      errors++;
      $display("FAIL clr_mid busy=%b out_valid=%b in_ready=%b product=%h required 0/0/1/%h", bus.busy, bus.out_valid, bus.in_ready, bus.out_product, held);
    end
    run_job("s6_after_clr", 8'd3, 8'd5, 0, 0, 0, 16'h000F);
    // clr in DONE alongside an output handshake keeps the registered product.
    build(8'd2, 8'd7, 0);
    send_beats(K);
    bus.clr = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0; bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_product !== 16'h000E) begin
      errors++;
      $display("FAIL clr_done out_valid=%b busy=%b product=%h required 0/0/000e", bus.out_valid, bus.busy, bus.out_product);
    end
    build(8'd3, 8'd5, 0);
    send_beats(3);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_product !== '0) begin
      errors++;
      $display("FAIL async_rst busy=%b out_valid=%b in_ready=%b product=%h required 0/0/1/0", bus.busy, bus.out_valid, bus.in_ready, bus.out_product);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_job("s6_after_rst", 8'd3, 8'd5, 0, 0, 0, 16'h000F);
  endtask

  task automatic test_random();
    logic [N-1:0] x, y;
    logic [2*N-1:0] xw, yw;
    for (int j = 0; j < 25; j++) begin
      x = N'($urandom); y = N'($urandom);
      if (j == 0) x = '0;
      if (j == 1) y = '0;
      xw = {{N{1'b0}}, x}; yw = {{N{1'b0}}, y};
      run_job("rand", x, y, 2, $urandom_range(0, 2), $urandom_range(0, 3), xw * yw);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] x, y;
    logic [2*N-1:0] xw, yw;
    int t_prev, t_now;
    t_prev = cyc;
    for (int j = 0; j < 6; j++) begin
      x = N'($urandom); y = N'($urandom);
      xw = {{N{1'b0}}, x}; yw = {{N{1'b0}}, y};
      t_now = cyc;
      if (j > 0) begin
        checks++;
        if (t_now - t_prev > K + 2) begin
          errors++; $display("FAIL b2b_period got=%0d cycles required<=%0d", t_now - t_prev, K + 2);
        end
      end
      t_prev = t_now;
      run_job("b2b", x, y, 2, 0, 0, xw * yw);
    end
  endtask

  initial begin
    bus.clr = 1'b0; bus.in_valid = 1'b0; bus.in_pp = '0; bus.in_sign = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_gaps();
    test_abort();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout time=%0t required finish earlier", $time);
    $fatal(1, "watchdog");
  end
endmodule
